// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86 data-memory controller slice:
//   - icode constants (HALT .. POP)
//   - response status codes (AOK, HLT, ADR, INS)
//   - controller FSM state type and decoded memory-access kind
// ----------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] HALT  = 4'h0;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [3:0] CMOV  = 4'h2;
    localparam logic [3:0] IRMOV = 4'h3;
    localparam logic [3:0] RMMOV = 4'h4;
    localparam logic [3:0] MRMOV = 4'h5;
    localparam logic [3:0] OPQ   = 4'h6;
    localparam logic [3:0] JXX   = 4'h7;
    localparam logic [3:0] CALL  = 4'h8;
    localparam logic [3:0] RET   = 4'h9;
    localparam logic [3:0] PUSH  = 4'hA;
    localparam logic [3:0] POP   = 4'hB;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } access_t;

endpackage

// File: rtl/y86_dmem_ctrl_if.sv
// ----------------------------------------------------------------------------
// y86_dmem_ctrl_if
// Bundles the memory-stage request/response handshake and the data-memory
// req/gnt/rvalid bus of the controller.
//   slave  : controller view (accepts requests, drives responses and memory)
//   master : environment view (memory stage plus data memory)
// ----------------------------------------------------------------------------
interface y86_dmem_ctrl_if #(
    parameter int unsigned AW = 12
) ();
    // memory-stage request
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_icode;
    logic [63:0]   req_valA;
    logic [63:0]   req_valE;
    logic [63:0]   req_valP;
    logic          req_pc_err;
    logic          req_ins_err;
    logic [63:0]   num_valid_instr;
    // memory-stage response
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_valM;
    logic [2:0]    rsp_stat;
    logic          rsp_addr_err;
    logic          rsp_data_err;
    logic          rsp_mem_used;
    // data memory
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [63:0]   mem_rdata;

    modport slave (
        input  req_valid, req_icode, req_valA, req_valE, req_valP,
               req_pc_err, req_ins_err, num_valid_instr,
               rsp_ready, mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_valM, rsp_stat, rsp_addr_err,
               rsp_data_err, rsp_mem_used, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_icode, req_valA, req_valE, req_valP,
               req_pc_err, req_ins_err, num_valid_instr,
               rsp_ready, mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_valM, rsp_stat, rsp_addr_err,
               rsp_data_err, rsp_mem_used, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/y86_dmem_decode.sv
// ----------------------------------------------------------------------------
// y86_dmem_decode
// Combinational icode decode for the data-memory controller.
//   i_icode, i_valA, i_valE, i_valP : memory-stage operands
//   o_access    : none / read / write
//   o_addr      : low AW bits of the selected address
//   o_wdata     : write data (0 for non-writes)
//   o_range_err : access with full 64-bit unsigned address >= MEM_DEPTH
//   o_is_ret    : read is a ret (its data is range-checked as a PC)
// ----------------------------------------------------------------------------
module y86_dmem_decode
    import y86_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 4096,
    parameter int unsigned AW        = 12
) (
    input  logic [3:0]    i_icode,
    input  logic [63:0]   i_valA,
    input  logic [63:0]   i_valE,
    input  logic [63:0]   i_valP,
    output access_t       o_access,
    output logic [AW-1:0] o_addr,
    output logic [63:0]   o_wdata,
    output logic          o_range_err,
    output logic          o_is_ret
);
    logic [63:0] w_addr;

    always_comb begin
        o_access = ACC_NONE;
        w_addr   = '0;
        o_wdata  = '0;
        o_is_ret = 1'b0;
        case (i_icode)
            RMMOV, PUSH: begin
                o_access = ACC_WRITE;
                w_addr   = i_valE;
                o_wdata  = i_valA;
            end
            CALL: begin
                o_access = ACC_WRITE;
                w_addr   = i_valE;
                o_wdata  = i_valP;
            end
            MRMOV: begin
                o_access = ACC_READ;
                w_addr   = i_valE;
            end
            POP: begin
                o_access = ACC_READ;
                w_addr   = i_valA;
            end
            RET: begin
                o_access = ACC_READ;
                w_addr   = i_valA;
                o_is_ret = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_addr      = w_addr[AW-1:0];
    assign o_range_err = (o_access != ACC_NONE) && (w_addr >= 64'(MEM_DEPTH));

endmodule

// File: rtl/y86_dmem_ctrl.sv
// ----------------------------------------------------------------------------
// y86_dmem_ctrl
// Sequencing controller between the SEQ memory stage and a single-port,
// variable-latency data memory.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : y86_dmem_ctrl_if.slave
//         req_*  : request handshake (accepted only in IDLE)
//         rsp_*  : response handshake (held in RESP until rsp_ready)
//         mem_*  : req/gnt/rvalid memory bus with TIMEOUT abort
// ----------------------------------------------------------------------------
module y86_dmem_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 4096,
    parameter int unsigned AW        = 12,
    parameter int unsigned TIMEOUT   = 16
) (
    input logic             clk,
    input logic             rst,
    y86_dmem_ctrl_if.slave  bus
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_we;
    logic          r_is_ret;
    logic [AW-1:0] r_addr;
    logic [63:0]   r_wdata;
    logic [63:0]   r_nvi;
    logic [63:0]   r_valM;
    logic [2:0]    r_stat;
    logic          r_addr_err;
    logic          r_data_err;
    logic          r_mem_used;
    logic [CW-1:0] r_cnt;

    access_t       w_access;
    logic [AW-1:0] w_addr;
    logic [63:0]   w_wdata;
    logic          w_range_err;
    logic          w_is_ret;
    logic          w_accept;
    logic          w_go_issue;
    logic [2:0]    w_acc_stat;
    logic          w_acc_addr_err;
    logic          w_timeout;
    logic          w_ret_bad;

    y86_dmem_decode #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_decode (
        .i_icode     (bus.req_icode),
        .i_valA      (bus.req_valA),
        .i_valE      (bus.req_valE),
        .i_valP      (bus.req_valP),
        .o_access    (w_access),
        .o_addr      (w_addr),
        .o_wdata     (w_wdata),
        .o_range_err (w_range_err),
        .o_is_ret    (w_is_ret)
    );

    assign w_accept  = bus.req_valid && (r_state == IDLE);
    // counter starts at 0 on entry, so expiry is the TIMEOUT-th cycle spent waiting
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    assign w_ret_bad = r_is_ret && (bus.mem_rdata > r_nvi);

    // accept-time priority: first matching condition decides the outcome
    always_comb begin
        w_acc_stat     = AOK;
        w_acc_addr_err = 1'b0;
        w_go_issue     = 1'b0;
        if (bus.req_pc_err) begin
            w_acc_stat = ADR;
        end else if (bus.req_ins_err) begin
            w_acc_stat = INS;
        end else if (bus.req_icode == HALT) begin
            w_acc_stat = HLT;
        end else if (w_access == ACC_NONE) begin
            w_acc_stat = AOK;
        end else if (w_range_err) begin
            w_acc_stat     = ADR;
            w_acc_addr_err = 1'b1;
        end else begin
            w_go_issue = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // gnt/rvalid are tested ahead of w_timeout so they win a same-cycle expiry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_go_issue ? ISSUE : RESP;
            ISSUE: begin
                if (bus.mem_gnt)    w_state_nxt = r_we ? RESP : WAIT_R;
                else if (w_timeout) w_state_nxt = RESP;
            end
            WAIT_R:  if (bus.mem_rvalid || w_timeout) w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_is_ret   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_nvi      <= '0;
            r_valM     <= '0;
            r_stat     <= AOK;
            r_addr_err <= 1'b0;
            r_data_err <= 1'b0;
            r_mem_used <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we       <= (w_access == ACC_WRITE);
                        r_is_ret   <= w_is_ret;
                        r_addr     <= w_addr;
                        r_wdata    <= w_wdata;
                        r_nvi      <= bus.num_valid_instr;
                        r_valM     <= '0;
                        r_stat     <= w_acc_stat;
                        r_addr_err <= w_acc_addr_err;
                        r_data_err <= 1'b0;
                        r_mem_used <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                ISSUE: begin
                    if (bus.mem_gnt) begin
                        if (r_we) r_mem_used <= 1'b1;
                        r_cnt <= '0;
                    end else if (w_timeout) begin
                        r_data_err <= 1'b1;
                        r_stat     <= ADR;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WAIT_R: begin
                    if (bus.mem_rvalid) begin
                        r_valM     <= bus.mem_rdata;
                        r_mem_used <= 1'b1;
                        if (w_ret_bad) begin
                            r_data_err <= 1'b1;
                            r_stat     <= ADR;
                        end
                    end else if (w_timeout) begin
                        r_data_err <= 1'b1;
                        r_stat     <= ADR;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = (r_state == IDLE);
    assign bus.rsp_valid    = (r_state == RESP);
    assign bus.rsp_valM     = r_valM;
    assign bus.rsp_stat     = r_stat;
    assign bus.rsp_addr_err = r_addr_err;
    assign bus.rsp_data_err = r_data_err;
    assign bus.rsp_mem_used = r_mem_used;
    assign bus.mem_req      = (r_state == ISSUE);
    assign bus.mem_we       = r_we;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_wdata    = r_wdata;

endmodule

// File: tb/tb_y86_dmem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_y86_dmem_ctrl
// Scoreboard bench: the stimulus pushes the expected response at accept, a
// memory model answers req with programmable gnt/rvalid delays, and a
// monitor compares every cycle the DUT presents rsp_valid.
// ----------------------------------------------------------------------------
module tb_y86_dmem_ctrl;
    import y86_pkg::*;

    localparam int unsigned MEM_DEPTH = 4096;
    localparam int unsigned AW        = 12;
    localparam int unsigned TIMEOUT   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    y86_dmem_ctrl_if #(.AW(AW)) bus ();

    y86_dmem_ctrl #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] valM;
        logic [2:0]  stat;
        logic        addr_err;
        logic        data_err;
        logic        mem_used;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int gnt_delay  = 0;
    int rv_delay   = -1;
    int stray_mode = 0;
    int hold_cnt   = 0;
    logic [63:0]   rdata_val = '0;
    logic          exp_we    = 1'b0;
    logic [AW-1:0] exp_addr  = '0;
    logic [63:0]   exp_wdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // data memory model
    initial begin : mem_model
        int age;
        int rv_cnt;
        age = 0;
        rv_cnt = -1;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = rdata_val;
            if (rst) begin
                age = 0;
                rv_cnt = -1;
            end else begin
                if (rv_cnt > 0) rv_cnt--;
                if (rv_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    rv_cnt = -1;
                end
                if ((stray_mode == 1 && bus.rsp_valid) || (stray_mode == 2 && bus.req_ready)) begin
                    bus.mem_rvalid = 1'b1;
                    stray_mode = 0;
                end
                if (bus.mem_req) begin
                    if (gnt_delay >= 0 && age == gnt_delay) begin
                        bus.mem_gnt = 1'b1;
                        chk("mem_we", bus.mem_we, exp_we);
                        chk("mem_addr", bus.mem_addr, exp_addr);
                        chk("mem_wdata", bus.mem_wdata, exp_wdata);
                        if (!bus.mem_we && rv_delay >= 0) rv_cnt = rv_delay;
                    end
                    age++;
                end else begin
                    age = 0;
                end
            end
        end
    end

    // response back-pressure
    initial begin : ready_gen
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid && hold_cnt > 0) begin
                bus.rsp_ready = 1'b0;
                hold_cnt--;
            end else begin
                bus.rsp_ready = 1'b1;
            end
        end
    end

    // monitor / scoreboard
    initial begin : monitor
        bit first;
        first = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                first = 1'b1;
            end else if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=rsp_valid required=none t=%0t", $time);
                end else begin
                    if (first && q[0].lat > 0)
                        chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
                    first = 1'b0;
                    chk("rsp_valM", bus.rsp_valM, q[0].valM);
                    chk("rsp_stat", bus.rsp_stat, q[0].stat);
                    chk("rsp_addr_err", bus.rsp_addr_err, q[0].addr_err);
                    chk("rsp_data_err", bus.rsp_data_err, q[0].data_err);
                    chk("rsp_mem_used", bus.rsp_mem_used, q[0].mem_used);
                    chk("resp_req_ready", bus.req_ready, 0);
                    chk("resp_mem_req", bus.mem_req, 0);
                    if (bus.rsp_ready) begin
                        void'(q.pop_front());
                        first = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 0);
    endtask

    task automatic set_mem(input logic we, input logic [AW-1:0] addr, input logic [63:0] wdata,
                           input int gd, input int rvd, input logic [63:0] rdata);
        drain();
        exp_we    = we;
        exp_addr  = addr;
        exp_wdata = wdata;
        gnt_delay = gd;
        rv_delay  = rvd;
        rdata_val = rdata;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, input logic pe, input logic ie, output int acc);
        int n;
        @(posedge clk);
        #1;
        bus.req_icode   = ic;
        bus.req_valA    = a;
        bus.req_valE    = e;
        bus.req_valP    = p;
        bus.req_pc_err  = pe;
        bus.req_ins_err = ie;
        bus.req_valid   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", bus.req_ready, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                        input logic [63:0] p, input logic pe, input logic ie,
                        input logic [63:0] valM, input logic [2:0] stat, input logic ae,
                        input logic de, input logic mu, input int lat);
        exp_t x;
        int acc;
        drive(ic, a, e, p, pe, ie, acc);
        x.valM = valM; x.stat = stat; x.addr_err = ae; x.data_err = de;
        x.mem_used = mu; x.lat = lat; x.acc = acc;
        q.push_back(x);
    endtask

    task automatic rst_mid(input int gd, input int wait_n, input logic pre_req);
        int acc;
        set_mem(1'b0, 12'd20, 64'h0, gd, -1, 64'h0);
        drive(MRMOV, 64'h0, 64'd20, 64'h0, 1'b0, 1'b0, acc);
        repeat (wait_n) @(negedge clk);
        chk("pre_rst_mem_req", bus.mem_req, pre_req);
        chk("pre_rst_req_ready", bus.req_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        bus.req_valid       = 1'b0;
        bus.req_icode       = '0;
        bus.req_valA        = '0;
        bus.req_valE        = '0;
        bus.req_valP        = '0;
        bus.req_pc_err      = 1'b0;
        bus.req_ins_err     = 1'b0;
        bus.num_valid_instr = 64'd40;

        #12;
        chk("rst_req_ready0", bus.req_ready, 1);
        chk("rst_rsp_valid0", bus.rsp_valid, 0);
        chk("rst_mem_req0", bus.mem_req, 0);
        chk("rst_mem_we0", bus.mem_we, 0);
        chk("rst_mem_addr0", bus.mem_addr, 0);
        chk("rst_mem_wdata0", bus.mem_wdata, 0);
        chk("rst_valM0", bus.rsp_valM, 0);
        chk("rst_stat0", bus.rsp_stat, 1);
        chk("rst_flags0", {bus.rsp_addr_err, bus.rsp_data_err, bus.rsp_mem_used}, 0);
        @(negedge clk);
        rst = 1'b0;

        // rmmovq, immediate gnt
        set_mem(1'b1, 12'd100, 64'h55, 0, -1, 64'h0);
        send(RMMOV, 64'h55, 64'd100, 64'h0, 1'b0, 1'b0, 64'h0, AOK, 1'b0, 1'b0, 1'b1, 2);
        // mrmovq, rvalid 3 cycles after gnt, response held 4 cycles
        set_mem(1'b0, 12'd200, 64'h0, 0, 3, 64'hABCD);
        hold_cnt = 4;
        send(MRMOV, 64'h0, 64'd200, 64'h0, 1'b0, 1'b0, 64'hABCD, AOK, 1'b0, 1'b0, 1'b1, 5);
        // address range boundaries
        set_mem(1'b1, 12'hFFF, 64'h77, 0, -1, 64'h0);
        send(PUSH, 64'h7, 64'd4096, 64'h0, 1'b0, 1'b0, 64'h0, ADR, 1'b1, 1'b0, 1'b0, 1);
        send(PUSH, 64'h77, 64'd4095, 64'h0, 1'b0, 1'b0, 64'h0, AOK, 1'b0, 1'b0, 1'b1, 2);
        set_mem(1'b1, 12'd100, 64'h9, 0, -1, 64'h0);
        send(RMMOV, 64'h9, 64'h8000_0000_0000_0064, 64'h0, 1'b0, 1'b0, 64'h0, ADR, 1'b1, 1'b0, 1'b0, 1);
        // halt and no-access
        send(HALT, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, HLT, 1'b0, 1'b0, 1'b0, 1);
        send(OPQ, 64'h3, 64'd50, 64'h0, 1'b0, 1'b0, 64'h0, AOK, 1'b0, 1'b0, 1'b0, 1);
        // call writes valP, gnt after 2 wait cycles
        set_mem(1'b1, 12'd300, 64'h1234, 2, -1, 64'h0);
        send(CALL, 64'h5, 64'd300, 64'h1234, 1'b0, 1'b0, 64'h0, AOK, 1'b0, 1'b0, 1'b1, 4);
        // ret target checks against num_valid_instr = 40
        set_mem(1'b0, 12'd8, 64'h0, 0, 1, 64'd50);
        send(RET, 64'd8, 64'h0, 64'h0, 1'b0, 1'b0, 64'd50, ADR, 1'b0, 1'b1, 1'b1, 3);
        set_mem(1'b0, 12'd8, 64'h0, 0, 1, 64'd40);
        send(RET, 64'd8, 64'h0, 64'h0, 1'b0, 1'b0, 64'd40, AOK, 1'b0, 1'b0, 1'b1, 3);
        set_mem(1'b0, 12'd16, 64'h0, 0, 1, 64'd50);
        send(POP, 64'd16, 64'h0, 64'h0, 1'b0, 1'b0, 64'd50, AOK, 1'b0, 1'b0, 1'b1, 3);
        // gnt timeout, stray rvalid during RESP and then in IDLE
        set_mem(1'b0, 12'd16, 64'h0, -1, -1, 64'hDEAD);
        stray_mode = 1;
        hold_cnt = 3;
        send(POP, 64'd16, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, ADR, 1'b0, 1'b1, 1'b0, 17);
        set_mem(1'b0, 12'd0, 64'h0, 0, -1, 64'hDEAD);
        stray_mode = 2;
        send(NOP, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, AOK, 1'b0, 1'b0, 1'b0, 1);
        // rvalid timeout
        set_mem(1'b0, 12'd200, 64'h0, 0, -1, 64'h0);
        send(MRMOV, 64'h0, 64'd200, 64'h0, 1'b0, 1'b0, 64'h0, ADR, 1'b0, 1'b1, 1'b0, 18);
        // gnt / rvalid on the last cycle before expiry win
        set_mem(1'b1, 12'd5, 64'h9, 15, -1, 64'h0);
        send(RMMOV, 64'h9, 64'd5, 64'h0, 1'b0, 1'b0, 64'h0, AOK, 1'b0, 1'b0, 1'b1, 17);
        set_mem(1'b0, 12'd6, 64'h0, 0, 16, 64'h99);
        send(MRMOV, 64'h0, 64'd6, 64'h0, 1'b0, 1'b0, 64'h99, AOK, 1'b0, 1'b0, 1'b1, 18);
        // fetch / decode errors
        send(MRMOV, 64'h0, 64'd6, 64'h0, 1'b1, 1'b1, 64'h0, ADR, 1'b0, 1'b0, 1'b0, 1);
        send(RMMOV, 64'h0, 64'd6, 64'h0, 1'b0, 1'b1, 64'h0, INS, 1'b0, 1'b0, 1'b0, 1);
        send(HALT, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, ADR, 1'b0, 1'b0, 1'b0, 1);
        // reset mid-ISSUE and mid-WAIT_R, then a normal write
        rst_mid(-1, 2, 1'b1);
        rst_mid(0, 3, 1'b0);
        set_mem(1'b1, 12'd100, 64'h55, 0, -1, 64'h0);
        send(RMMOV, 64'h55, 64'd100, 64'h0, 1'b0, 1'b0, 64'h0, AOK, 1'b0, 1'b0, 1'b1, 2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
